// File: rtl/riscv_immgen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with PC-relative target.
// A one-entry skid buffer keeps in_ready registered at full throughput.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holds valid and its payload until that edge, and ready never
// depends combinationally on valid of the same channel.

module riscv_immgen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [2:0]      ExtOp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o,
    output logic            err_o
);

    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    // Encoding is {OUT.valid, SKID.valid}, so the valid bits are the state.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } pipe_state_e;

    pipe_state_e     state_q, state_d;

    logic [XLEN-1:0] imm_new;
    logic [XLEN-1:0] tgt_new;
    logic            err_new;

    logic [XLEN-1:0] out_imm_q, out_tgt_q;
    logic            out_err_q;
    logic [XLEN-1:0] skid_imm_q, skid_tgt_q;
    logic            skid_err_q;

    logic            skid_valid;
    logic            acc, pop;
    logic            load_out_in, load_out_skid, load_skid;

    // Opcode bits never contribute to any immediate.
    logic [6:0]      inst_unused;
    assign inst_unused = inst_i[6:0];

    always_comb begin
        imm_new = '0;
        err_new = 1'b0;
        case (ExtOp)
            3'b000: imm_new = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
            3'b001: imm_new = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'b0};
            3'b010: imm_new = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            3'b011: imm_new = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25],
                               inst_i[11:8], 1'b0};
            3'b100: imm_new = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20],
                               inst_i[30:21], 1'b0};
            3'b101: imm_new = {{(XLEN-5){1'b0}}, inst_i[19:15]};
            3'b110: imm_new = {{(XLEN-SHAMT_W){1'b0}}, inst_i[20 +: SHAMT_W]};
            default: err_new = 1'b1;
        endcase
    end

    assign tgt_new = pc_i + imm_new;

    assign out_valid  = state_q[1];
    assign skid_valid = state_q[0];
    assign in_ready   = !skid_valid && !rst;

    assign acc = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d     = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    load_out_in = 1'b1;
                end else if (acc) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d       = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any same-cycle accept or refill.
        if (flush_i) begin
            state_d       = EMPTY;
            load_out_in   = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_imm_q  <= '0;
            out_tgt_q  <= '0;
            out_err_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_tgt_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_out_in) begin
                out_imm_q <= imm_new;
                out_tgt_q <= tgt_new;
                out_err_q <= err_new;
            end else if (load_out_skid) begin
                out_imm_q <= skid_imm_q;
                out_tgt_q <= skid_tgt_q;
                out_err_q <= skid_err_q;
            end
            if (load_skid) begin
                skid_imm_q <= imm_new;
                skid_tgt_q <= tgt_new;
                skid_err_q <= err_new;
            end
        end
    end

    assign imm_o    = out_imm_q;
    assign target_o = out_tgt_q;
    assign err_o    = out_err_q;

endmodule

// File: tb/tb_riscv_immgen_pipe.sv
// Scoreboard bench for riscv_immgen_pipe: XLEN=32 and XLEN=64 instances share
// the same stimulus; a negedge monitor checks outputs against an expected queue.

module tb_riscv_immgen_pipe;

    localparam int W = 32 + 32 + 64 + 64 + 1;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst_i;
    logic [2:0]  ExtOp;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32, tgt32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64, tgt64;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    assign pc64 = {32'b0, pc32};

    riscv_immgen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready32),
        .inst_i(inst_i), .pc_i(pc32), .ExtOp(ExtOp),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm_o(imm32), .target_o(tgt32), .err_o(err32)
    );

    riscv_immgen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready64),
        .inst_i(inst_i), .pc_i(pc64), .ExtOp(ExtOp),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm_o(imm64), .target_o(tgt64), .err_o(err64)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // driver: one clock cycle of stimulus, pushes the expectation on acceptance
    task automatic step(input logic v, input logic [31:0] inst, input logic [2:0] op,
                        input logic [31:0] pc, input logic fl, input logic [31:0] e32,
                        input logic [63:0] e64, input logic eerr, output logic acc);
        logic [31:0] t32;
        logic [63:0] t64;
        in_valid = v;
        inst_i   = inst;
        ExtOp    = op;
        pc32     = pc;
        flush_i  = fl;
        t32 = pc + e32;
        t64 = {32'b0, pc} + e64;
        @(negedge clk);
        acc = v && in_ready32 && !rst;
        @(posedge clk);
        if (fl || rst) exp_q.delete();
        else if (acc) exp_q.push_back({e32, t32, e64, t64, eerr});
        #1;
        in_valid = 1'b0;
        flush_i  = 1'b0;
    endtask

    task automatic idle(input logic fl);
        logic acc;
        step(1'b0, 32'h0, 3'b000, 32'h0, fl, 32'h0, 64'h0, 1'b0, acc);
    endtask

    task automatic send(input logic [31:0] inst, input logic [2:0] op, input logic [31:0] pc,
                        input logic [31:0] e32, input logic [63:0] e64, input logic eerr,
                        output int tries);
        logic acc;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, inst, op, pc, 1'b0, e32, e64, eerr, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: inst %h not accepted within %0d cycles", inst, tries);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        check("out_valid32", out_valid32, exp_q.size() != 0);
        check("out_valid64", out_valid64, exp_q.size() != 0);
        if (out_valid32 && exp_q.size() != 0) begin
            e = exp_q[0];
            check("imm32", imm32, e[192:161]);
            check("tgt32", tgt32, e[160:129]);
            check("imm64", imm64, e[128:65]);
            check("tgt64", tgt64, e[64:1]);
            check("err32", err32, e[0]);
            check("err64", err64, e[0]);
            if (out_ready) void'(exp_q.pop_front());
        end
    end

    initial begin
        int tries;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        inst_i    = '0;
        ExtOp     = '0;
        pc32      = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid32, 1'b0);
        check("rst_imm", imm32, 32'h0);
        check("rst_target", tgt32, 32'h0);
        check("rst_err", err32, 1'b0);
        check("rst_in_ready", in_ready32, 1'b0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready32, 1'b1);

        // streamed directed vectors, out_ready held high: one accept per cycle
        send(32'hFFF00093, 3'b000, 32'h80000000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, tries);
        check("tput_i", tries, 1);
        send(32'hFE000EE3, 3'b011, 32'h80000010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, tries);
        check("tput_b", tries, 1);
        send(32'h0080006F, 3'b100, 32'h80000000, 32'h00000008, 64'h0000000000000008, 1'b0, tries);
        check("tput_j", tries, 1);
        send(32'h800000B7, 3'b001, 32'h00001000, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, tries);
        send(32'h000F8073, 3'b101, 32'h00002000, 32'h0000001F, 64'h000000000000001F, 1'b0, tries);
        send(32'h03F01013, 3'b110, 32'h00003000, 32'h0000001F, 64'h000000000000003F, 1'b0, tries);
        send(32'h12345678, 3'b111, 32'h00000100, 32'h00000000, 64'h0000000000000000, 1'b1, tries);
        send(32'hFE112E23, 3'b010, 32'h00000040, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, tries);
        send(32'h7FF00013, 3'b000, 32'hFFFFF900, 32'h000007FF, 64'h00000000000007FF, 1'b0, tries);
        send(32'hFFDFF06F, 3'b100, 32'h00000010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, tries);
        check("tput_last", tries, 1);
        repeat (2) idle(1'b0);

        // backpressure: A, B, C with out_ready low for two cycles
        out_ready = 1'b0;
        send(32'h00100093, 3'b000, 32'h00000000, 32'h00000001, 64'h1, 1'b0, tries);
        send(32'h00200093, 3'b000, 32'h00000000, 32'h00000002, 64'h2, 1'b0, tries);
        #1;
        check("in_ready_full", in_ready32, 1'b0);
        fork
            send(32'h00300093, 3'b000, 32'h00000000, 32'h00000003, 64'h3, 1'b0, tries);
            begin
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("c_wait_cycles", tries, 3);
        repeat (3) idle(1'b0);

        // flush in FULL with a same-cycle input
        out_ready = 1'b0;
        send(32'h00400093, 3'b000, 32'h0, 32'h4, 64'h4, 1'b0, tries);
        send(32'h00500093, 3'b000, 32'h0, 32'h5, 64'h5, 1'b0, tries);
        begin
            logic acc;
            step(1'b1, 32'h00600093, 3'b000, 32'h0, 1'b1, 32'h6, 64'h6, 1'b0, acc);
        end
        check("flush_out_valid", out_valid32, 1'b0);
        check("flush_in_ready", in_ready32, 1'b1);
        // flush in ONE where the same-cycle input would have been accepted
        send(32'h00700093, 3'b000, 32'h0, 32'h7, 64'h7, 1'b0, tries);
        begin
            logic acc;
            step(1'b1, 32'h00800093, 3'b000, 32'h0, 1'b1, 32'h8, 64'h8, 1'b0, acc);
        end
        check("flush1_out_valid", out_valid32, 1'b0);
        out_ready = 1'b1;
        repeat (3) idle(1'b0);

        // reset while FULL, OUT holding a reserved-format entry
        out_ready = 1'b0;
        send(32'h12345678, 3'b111, 32'h00000200, 32'h0, 64'h0, 1'b1, tries);
        send(32'h00900093, 3'b000, 32'h00000000, 32'h9, 64'h9, 1'b0, tries);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", in_ready32, 1'b0);
        idle(1'b0);
        check("rst_mid_out_valid", out_valid32, 1'b0);
        check("rst_mid_imm", imm32, 32'h0);
        check("rst_mid_target", tgt32, 32'h0);
        check("rst_mid_err", err32, 1'b0);
        check("rst_mid_in_ready2", in_ready32, 1'b0);
        idle(1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_mid_release", in_ready32, 1'b1);
        send(32'h00A00093, 3'b000, 32'h00000004, 32'hA, 64'hA, 1'b0, tries);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b0);
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_immgen_pipe.md
# riscv_immgen_pipe

Pipelined, parametrised immediate generator for the NPC decode path. It accepts one instruction per cycle over a valid/ready handshake and extracts its immediate for any RV32I/RV64I format, including the CSR zimm and shift-amount formats, sign- or zero-extended to XLEN. Alongside the immediate it computes the PC-relative target `pc + imm`. It sits between instruction fetch/decode and the execute stage. A one-entry skid buffer registers `in_ready` while keeping full throughput.

## Interface
- `XLEN`, default 32: datapath width; legal values 32 and 64.
- `SHAMT_W`, default `XLEN==64 ? 6 : 5`: shift-amount field width; derived, not overridden.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush_i` in 1: discard all buffered entries.
- `in_valid` in 1: input entry valid.
- `in_ready` out 1: block can accept an entry this cycle.
- `inst_i` in 32: raw instruction word.
- `pc_i` in XLEN: PC of `inst_i`.
- `ExtOp` in 3: format select. The encoding is:
  - 000 I
  - 001 U
  - 010 S
  - 011 B
  - 100 J
  - 101 Z (CSR zimm)
  - 110 SH (shamt)
  - 111 reserved
- `out_valid` out 1: output entry valid.
- `out_ready` in 1: consumer accepts the output this cycle.
- `imm_o` out XLEN: extended immediate.
- `target_o` out XLEN: `pc_i + imm`, modulo 2^XLEN.
- `err_o` out 1: entry carried a reserved ExtOp.

## Operation
- Immediate extraction (`s` = `inst_i[31]` replicated to XLEN):
  - I: `s`, `inst[31:20]`.
  - S: `s`, `inst[31:25]`, `inst[11:7]`.
  - B: `s`, `inst[7]`, `inst[30:25]`, `inst[11:8]`, 0.
  - J: `s`, `inst[19:12]`, `inst[20]`, `inst[30:21]`, 0.
  - U: `inst[31:12]`, 12'b0, sign-extended from bit 31 when XLEN=64.
  - Z: zero-extend `inst[19:15]`.
  - SH: zero-extend `inst[20+SHAMT_W-1:20]`.
  - Reserved: `imm` = 0 and `err` = 1. The entry still flows through the pipe; it is not dropped.
- `target` is always `pc_i + imm`, with carry out discarded. It is computed for every format, including Z, SH and reserved.
- Storage consists of an output register (OUT) and a skid register (SKID), each holding {imm, target, err, valid}.
- Pipe states, encoded by the two valid bits:
  - EMPTY (OUT invalid, SKID invalid).
  - ONE (OUT valid, SKID invalid).
  - FULL (OUT valid, SKID valid).
- `in_ready = !SKID.valid`, taken directly from a register.
- A transfer happens when `valid && ready` on the same edge.
- Transitions (acc = input transfer, pop = output transfer):
  - EMPTY, acc → ONE.
  - ONE, acc without pop → FULL (new entry goes to SKID).
  - ONE, acc with pop → ONE (new entry goes to OUT).
  - ONE, pop only → EMPTY.
  - FULL, pop → ONE (SKID moves to OUT). No acc is possible in FULL.
  - FULL, no pop → hold.
- Ordering is strictly FIFO. An entry in SKID is never overtaken.
- `flush_i` invalidates OUT and SKID on the next edge.
  - It has priority over a same-cycle acc; that entry is discarded.
  - It has priority over a same-cycle pop; the pop completes for the consumer, but nothing refills.
- Output data and `err_o` are held stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid` 0, `imm_o` 0, `target_o` 0, `err_o` 0. SKID is cleared.
- `in_ready` is 0 while `rst` is high and 1 on the first cycle after deassertion.
- Reset mid-operation discards all entries, exactly like a flush, and reset dominates flush.
- Latency is 1 cycle: an entry accepted at edge N is on the outputs after edge N.
- Throughput is 1 entry/cycle while `out_ready` stays high.
- After one `out_ready`-low cycle with input streaming, `in_ready` drops for exactly one cycle.
- No combinational path from `out_ready` to `in_ready`.
- Combinational paths: `inst_i`/`pc_i`/`ExtOp` → register inputs only.

## Test plan
- I/B, XLEN=32:
  - `inst 0xFFF00093`, ExtOp 000, pc `0x80000000` → `imm 0xFFFFFFFF`, `target 0x7FFFFFFF`, err 0, one cycle later.
  - `inst 0xFE000EE3`, ExtOp 011, pc `0x80000010` → `imm 0xFFFFFFFC`, `target 0x8000000C`.
- J/U across XLEN:
  - `0x0080006F`, ExtOp 100, pc `0x80000000` → `imm 8`, `target 0x80000008`.
  - `0x800000B7`, ExtOp 001 → `imm 0x80000000` at XLEN=32, `0xFFFFFFFF80000000` at XLEN=64.
- Z/SH/reserved:
  - `inst[19:15]=11111`, ExtOp 101 → `imm 0x1F`.
  - `inst[25:20]=111111`, ExtOp 110 → 63 (XLEN=64) or 31 (XLEN=32).
  - ExtOp 111 → `imm 0`, `err_o 1`.
- Backpressure: stream entries A, B, C with `out_ready` low for 2 cycles.
  - `in_ready` falls after B is accepted.
  - A is held stable while `out_ready` is low.
  - Outputs appear in order A, B, C with no loss or duplication.
- Flush: in FULL, assert `flush_i` together with `in_valid` → next cycle `out_valid` 0, `in_ready` 1, and the flushed input is never output.
- Reset: assert `rst` in FULL → all outputs zero, `in_ready` 0 during reset and 1 on the cycle after release.
